sram_col_access_ctrl: RTL
=========================

// Module: sram_col_access_ctrl
// PURPOSE
//  Access sequencer on the core side of the 64-row x 4:1 column-muxed 32-bit SRAM array.
//  Accepts one read or write request at a time and sequences the array controls:
//  precharge, wordline, column select (the S input of each column mux) and write_en (mux direction).
//  For reads it fires sense_en, captures the sensed word and returns it on a response strobe.
//  It is the initiator of the column-mux protocol; the muxes and array respond.
// PARAMETERS
//  ROW_BITS  6   wordline address bits (2**ROW_BITS wordlines)
//  COL_BITS  2   column-mux select bits (2**COL_BITS-way mux)
//  DATA_W    32  word width
//  PRE_CYC   1   precharge cycles, >=1
//  WL_CYC    2   wordline-active cycles, >=1; sense_en is asserted in the last one
// PORTS
//  clk          in   1                  clock, all state updates on rising edge
//  rst_n        in   1                  asynchronous active-low reset
//  req_valid    in   1                  request present
//  req_ready    out  1                  controller can accept; high only in IDLE
//  req_we       in   1                  1 = write, 0 = read
//  req_addr     in   ROW_BITS+COL_BITS  {row, col}; col = LSBs
//  req_wdata    in   DATA_W             write data
//  rsp_valid    out  1                  one-cycle completion strobe (reads and writes)
//  rsp_we       out  1                  type of the completed access
//  rsp_rdata    out  DATA_W             read data; 0 on write completion
//  precharge_en out  1                  bitline precharge
//  wl_sel       out  2**ROW_BITS        one-hot wordline enable
//  col_sel      out  2**COL_BITS        one-hot column-mux select
//  write_en     out  1                  mux direction: 1 = drive toward cells
//  sense_en     out  1                  sense-amp enable
//  bl_wdata     out  DATA_W             data driven toward the muxes on writes
//  bl_rdata     in   DATA_W             sensed data from the muxes
// BEHAVIOUR
//  All array-side outputs and rsp_* are registered. req_ready = (state==IDLE).
//  Reset (async, rst_n=0): state IDLE; every output 0 except req_ready=1 once in IDLE.
//   This includes precharge_en, wl_sel, col_sel, write_en, sense_en, bl_wdata, rsp_*.
//   Reset mid-access drops all controls at once, issues no response and discards the latched request.
//  FSM: IDLE -> PRECH -> WL -> RESP -> IDLE.
//   IDLE : accepts when req_valid & req_ready; latches we/addr/wdata; goes to PRECH.
//   PRECH: precharge_en=1 for PRE_CYC cycles; wl_sel, col_sel and write_en all 0.
//   WL   : wl_sel[row]=1, col_sel[col]=1, write_en=we, bl_wdata=wdata (0 on reads).
//          Held WL_CYC cycles.
//          Read: sense_en=1 in the last WL cycle only; bl_rdata is captured on the edge leaving WL.
//          Write: sense_en stays 0.
//   RESP : rsp_valid=1 for exactly one cycle with rsp_we and rsp_rdata; then IDLE.
//  Latency: with acceptance at edge 0, rsp_valid is high during cycle PRE_CYC+WL_CYC+1.
//   With defaults that is cycle 4. A new request can be accepted every PRE_CYC+WL_CYC+2 cycles (5 by default).
//  Break-before-make:
//   - precharge_en never overlaps any wl_sel or col_sel bit.
//   - write_en changes only while col_sel == 0.
//   - wl_sel and col_sel each have at most one bit set, and they are asserted and deasserted on the same edges.
//  req_valid outside IDLE is ignored; the request must be held until accepted, with no buffering.
//  Request inputs are sampled only on the accept edge; later changes do not affect the access in flight.
//  rsp_rdata holds its value until the next RESP or reset.
// TESTING
//  1 Write addr 0x5A (row 22, col 2), data 0xDEADBEEF.
//    -> wl_sel[22] and col_sel[2] high for 2 cycles, write_en=1, sense_en=0.
//    -> rsp_valid 4 cycles after accept, rsp_we=1, rsp_rdata=0.
//  2 Read addr 0x5A, model returns 0xDEADBEEF on bl_rdata.
//    -> precharge 1 cycle, sense_en only in the 2nd WL cycle.
//    -> rsp_rdata=0xDEADBEEF, rsp_we=0.
//  3 Hold req_valid high with 3 queued requests.
//    -> accepts spaced exactly 5 cycles apart; req_ready low during PRECH/WL/RESP.
//    -> req_addr changes between accepts have no effect on the access in flight.
//  4 Sweep all 256 addresses, checking each cycle.
//    -> wl_sel/col_sel one-hot and correct.
//    -> never any overlap of precharge_en with wl_sel or col_sel.
//    -> no write_en toggle while col_sel != 0.
//  5 Assert rst_n=0 mid-WL of a write.
//    -> all array controls are 0 before the next clock edge; no rsp_valid.
//    -> after release, req_ready=1 and the next read completes normally.
//  6 PRE_CYC=3, WL_CYC=1 build.
//    -> read response in cycle 5 after accept.
//    -> sense_en coincides with the single WL cycle.

Source files
------------

// File: rtl/sram_col_access_ctrl.sv
// Access sequencer for a row x column-muxed SRAM array: precharge, then wordline plus column
// select (with sense on reads), then a one-cycle response. Every array-side output is registered.
module sram_col_access_ctrl #(
  parameter int ROW_BITS = 6,
  parameter int COL_BITS = 2,
  parameter int DATA_W   = 32,
  parameter int PRE_CYC  = 1,
  parameter int WL_CYC   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_we,
  input  logic [ROW_BITS+COL_BITS-1:0] req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  output logic                         rsp_we,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         precharge_en,
  output logic [2**ROW_BITS-1:0]       wl_sel,
  output logic [2**COL_BITS-1:0]       col_sel,
  output logic                         write_en,
  output logic                         sense_en,
  output logic [DATA_W-1:0]            bl_wdata,
  input  logic [DATA_W-1:0]            bl_rdata
);

  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int CMAX  = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
  localparam int CNT_W = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {IDLE, PRECH, WL, RESP} state_t;

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   we_q, we_d;
  logic [AW-1:0]          addr_q, addr_d;
  logic [DATA_W-1:0]      wdata_q, wdata_d;
  logic                   pre_q, pre_d;
  logic [2**ROW_BITS-1:0] wl_q, wl_d;
  logic [2**COL_BITS-1:0] col_q, col_d;
  logic                   wen_q, wen_d;
  logic                   sen_q, sen_d;
  logic [DATA_W-1:0]      blw_q, blw_d;
  logic                   rv_q, rv_d;
  logic                   rwe_q, rwe_d;
  logic [DATA_W-1:0]      rdata_q, rdata_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rwe_d   = rwe_q;
    rdata_d = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          state_d = PRECH;
          cnt_d   = '0;
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
        end
      end
      PRECH: begin
        if (cnt_q == CNT_W'(PRE_CYC - 1)) begin
          state_d = WL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WL: begin
        if (cnt_q == CNT_W'(WL_CYC - 1)) begin
          state_d = RESP;
          cnt_d   = '0;
          rwe_d   = we_q;
          rdata_d = we_q ? '0 : bl_rdata;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    pre_d = (state_d == PRECH);
    wl_d  = '0;
    col_d = '0;
    sen_d = 1'b0;
    blw_d = '0;
    if (state_d == WL) begin
      wl_d[addr_q[AW-1:COL_BITS]]  = 1'b1;
      col_d[addr_q[COL_BITS-1:0]] = 1'b1;
      blw_d = we_q ? wdata_q : '0;
      sen_d = !we_q && (cnt_d == CNT_W'(WL_CYC - 1));
    end
    // write_en lingers through RESP so that it only ever falls while col_sel is already 0.
    wen_d = we_q && ((state_d == WL) || (state_d == RESP));
    rv_d  = (state_d == RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      pre_q   <= 1'b0;
      wl_q    <= '0;
      col_q   <= '0;
      wen_q   <= 1'b0;
      sen_q   <= 1'b0;
      blw_q   <= '0;
      rv_q    <= 1'b0;
      rwe_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      pre_q   <= pre_d;
      wl_q    <= wl_d;
      col_q   <= col_d;
      wen_q   <= wen_d;
      sen_q   <= sen_d;
      blw_q   <= blw_d;
      rv_q    <= rv_d;
      rwe_q   <= rwe_d;
      rdata_q <= rdata_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign precharge_en = pre_q;
  assign wl_sel       = wl_q;
  assign col_sel      = col_q;
  assign write_en     = wen_q;
  assign sense_en     = sen_q;
  assign bl_wdata     = blw_q;
  assign rsp_valid    = rv_q;
  assign rsp_we       = rwe_q;
  assign rsp_rdata    = rdata_q;

endmodule
